// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame streamer: FSM state encoding,
// default command opcodes and the CRC-8 polynomial with its byte-update helper.
package spi_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SIZE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_CRC   = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  localparam logic [7:0] CMD_SIZE_DEF  = 8'h7F;
  localparam logic [7:0] CMD_DATA_DEF  = 8'hBF;
  localparam logic [7:0] CMD_ABORT_DEF = 8'h3F;

  localparam logic [7:0] CRC_POLY = 8'h07;

  // CRC-8, MSB first: fold one byte into the running remainder
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_word_prefetch.sv
// SRAM read sequencer with a one-word prefetch register.
// A read is a one-cycle active-low sram_start pulse with sram_addr held;
// the word is captured on the first sram_ready seen after that pulse.
// 'take' consumes the held word and, unless it was the stop word,
// immediately issues the read of the next address.
module spi_word_prefetch
  import spi_frame_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    take,
  input  logic [ADDR_W-1:0]       stop_addr,
  input  logic                    sram_ready,
  input  logic [8*WORD_BYTES-1:0] sram_data,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic                    sram_start,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  output logic                    last
);

  logic [ADDR_W-1:0]       addr_r;
  logic                    start_r;
  logic                    wait_r;
  logic                    valid_r;
  logic [8*WORD_BYTES-1:0] word_r;

  assign sram_addr  = addr_r;
  assign sram_start = start_r;
  assign word_data  = word_r;
  assign word_valid = valid_r;
  // Compared before any increment, so an all-ones stop address never wraps
  assign last       = (addr_r == stop_addr);

  // Request pulse generation, address stepping and word capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= '0;
      start_r <= 1'b1;
      wait_r  <= 1'b0;
      valid_r <= 1'b0;
      word_r  <= '0;
    end else if (clear) begin
      addr_r  <= '0;
      start_r <= 1'b1;
      wait_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      start_r <= 1'b1;
      if (!start_r) begin
        wait_r <= 1'b1;
      end
      if (start) begin
        addr_r  <= '0;
        start_r <= 1'b0;
      end else if (take) begin
        valid_r <= 1'b0;
        if (!last) begin
          addr_r  <= addr_r + ADDR_W'(1);
          start_r <= 1'b0;
        end
      end
      if (wait_r && sram_ready) begin
        word_r  <= sram_data;
        valid_r <= 1'b1;
        wait_r  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_frame_streamer.sv
// SPI frame streamer: answers a size command with a big-endian length header,
// or a data command by streaming SRAM words 0..stop_addr (LSB byte first)
// into an SPI slave core byte by byte.
// Optional: define SPI_FRAME_STREAMER_CRC_EN to append a CRC-8 byte after the
// data and count it in the header length.
module spi_frame_streamer
  import spi_frame_pkg::*;
#(
  parameter int         ADDR_W     = 16,
  parameter int         WORD_BYTES = 2,
  parameter int         SIZE_BYTES = 3,
  parameter logic [7:0] CMD_SIZE   = CMD_SIZE_DEF,
  parameter logic [7:0] CMD_DATA   = CMD_DATA_DEF,
  parameter logic [7:0] CMD_ABORT  = CMD_ABORT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sram_ready,
  input  logic [8*WORD_BYTES-1:0] sram_data,
  input  logic [ADDR_W-1:0]       stop_addr,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic                    sram_start,
  output logic                    sram_rw,
  input  logic                    do_valid,
  input  logic [7:0]              spi_data_in,
  input  logic                    di_req,
  input  logic                    wr_ack,
  output logic [7:0]              spi_data_out,
  output logic                    wren,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int HW = 8 * SIZE_BYTES;
  localparam int DW = 8 * WORD_BYTES;

  state_e            state_r, state_nxt_s;
  logic [ADDR_W-1:0] stop_r;
  logic [HW-1:0]     hdr_r, hdr_calc_s;
  logic [DW-1:0]     sh_r;
  logic [2:0]        cnt_r;
  logic              sh_last_r;
  logic [7:0]        spi_data_out_r;
  logic              wren_r, busy_r, frame_done_r;
`ifdef SPI_FRAME_STREAMER_CRC_EN
  logic [7:0]        crc_r;
`endif

  logic              accept_size_s, accept_data_s, abortable_s, abort_s;
  logic              ack_s, last_byte_s, byte_pend_s, take_s, frame_end_s, pf_clear_s;
  logic [7:0]        byte_s;
  logic [DW-1:0]     pf_word_s;
  logic              pf_valid_s, pf_last_s;

  assign sram_rw      = 1'b1;
  assign spi_data_out = spi_data_out_r;
  assign wren         = wren_r;
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;

  spi_word_prefetch #(
    .ADDR_W     (ADDR_W),
    .WORD_BYTES (WORD_BYTES)
  ) u_prefetch (
    .clk        (clk),
    .reset      (reset),
    .clear      (pf_clear_s),
    .start      (accept_data_s),
    .take       (take_s),
    .stop_addr  (stop_r),
    .sram_ready (sram_ready),
    .sram_data  (sram_data),
    .sram_addr  (sram_addr),
    .sram_start (sram_start),
    .word_data  (pf_word_s),
    .word_valid (pf_valid_s),
    .last       (pf_last_s)
  );

  // Length header computed wide enough that stop_addr = all-ones cannot overflow
  always_comb begin
    hdr_calc_s = (HW'(stop_addr) + HW'(1'b1)) * HW'(WORD_BYTES);
`ifdef SPI_FRAME_STREAMER_CRC_EN
    hdr_calc_s = hdr_calc_s + HW'(1'b1);
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle control decode; abort overrides normal progress
  always_comb begin
    state_nxt_s   = state_r;
    accept_size_s = 1'b0;
    accept_data_s = 1'b0;
    abortable_s   = 1'b0;
    abort_s       = 1'b0;
    byte_s        = 8'h00;
    byte_pend_s   = 1'b0;
    take_s        = 1'b0;
    frame_end_s   = 1'b0;
    ack_s         = wren_r & wr_ack;
    last_byte_s   = (cnt_r == 3'd1);
    case (state_r)
      ST_IDLE: begin
        if (do_valid && (spi_data_in == CMD_SIZE)) begin
          accept_size_s = 1'b1;
          state_nxt_s   = ST_SIZE;
        end else if (do_valid && (spi_data_in == CMD_DATA)) begin
          accept_data_s = 1'b1;
          state_nxt_s   = ST_FETCH;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_SIZE: begin
        abortable_s = 1'b1;
        byte_s      = hdr_r[HW-1 -: 8];
        byte_pend_s = 1'b1;
        if (ack_s && last_byte_s) begin
          frame_end_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SIZE;
        end
      end
      ST_FETCH: begin
        abortable_s = 1'b1;
        if (pf_valid_s) begin
          take_s      = 1'b1;
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_SEND: begin
        abortable_s = 1'b1;
        byte_s      = sh_r[7:0];
        byte_pend_s = 1'b1;
        if (ack_s && last_byte_s && sh_last_r) begin
`ifdef SPI_FRAME_STREAMER_CRC_EN
          state_nxt_s = ST_CRC;
`else
          frame_end_s = 1'b1;
          state_nxt_s = ST_IDLE;
`endif
        end else if (ack_s && last_byte_s) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
`ifdef SPI_FRAME_STREAMER_CRC_EN
      ST_CRC: begin
        abortable_s = 1'b1;
        byte_s      = crc_r;
        byte_pend_s = 1'b1;
        if (ack_s) begin
          frame_end_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CRC;
        end
      end
`endif
      ST_DRAIN: begin
        if (!wren_r || wr_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (abortable_s && do_valid && (spi_data_in == CMD_ABORT)) begin
      abort_s     = 1'b1;
      take_s      = 1'b0;
      frame_end_s = 1'b0;
      state_nxt_s = ST_DRAIN;
    end else begin
      abort_s     = 1'b0;
    end
    pf_clear_s = abort_s | frame_end_s;
  end

  // Command latch, header shifter and word-to-byte shifter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stop_r    <= '0;
      hdr_r     <= '0;
      sh_r      <= '0;
      cnt_r     <= 3'd0;
      sh_last_r <= 1'b0;
    end else if (accept_size_s) begin
      stop_r    <= stop_addr;
      hdr_r     <= hdr_calc_s;
      cnt_r     <= 3'(SIZE_BYTES);
    end else if (accept_data_s) begin
      stop_r    <= stop_addr;
    end else if (take_s) begin
      sh_r      <= pf_word_s;
      cnt_r     <= 3'(WORD_BYTES);
      sh_last_r <= pf_last_s;
    end else if (ack_s) begin
      hdr_r     <= hdr_r << 8;
      sh_r      <= sh_r >> 8;
      cnt_r     <= cnt_r - 3'd1;
    end
  end

  // SPI byte handshake plus registered busy and frame_done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spi_data_out_r <= 8'h00;
      wren_r         <= 1'b0;
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      frame_done_r <= frame_end_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      if (ack_s) begin
        wren_r <= 1'b0;
      end else if (!wren_r && byte_pend_s && di_req && !abort_s) begin
        wren_r         <= 1'b1;
        spi_data_out_r <= byte_s;
      end
    end
  end

`ifdef SPI_FRAME_STREAMER_CRC_EN
  // Running CRC over data bytes as each one is acknowledged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_r <= 8'h00;
    end else if (accept_size_s || accept_data_s) begin
      crc_r <= 8'h00;
    end else if (ack_s && (state_r == ST_SEND)) begin
      crc_r <= crc8_byte(crc_r, spi_data_out_r);
    end
  end
`endif

endmodule
